// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared constants and fetch-state encoding for the fetch stage
// Purpose: XLEN, NOP encoding, default reset PC and the fetch FSM state enum.
// Ports: none (package).
package riscv_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;        // addi x0, x0, 0
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,   // issue request
    S_WAIT = 2'd1,   // await response
    S_HOLD = 2'd2,   // response buffered while stalled
    S_DROP = 2'd3    // await response that must be discarded
  } fetchStateT;

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with hold, bubble and flush
// Purpose: holds the fetched instruction and its PC for the decode stage.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   flush             squash to NOP (overrides stall and load)
//   stall             hold all outputs
//   load              capture instrIn/pcIn; otherwise a bubble is inserted
//   instrIn, pcIn     instruction and its PC to capture
//   valid, instr, pc, pcPlus4   registered IF/ID contents
module if_id_reg
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            stall,
  input  logic            load,
  input  logic [XLEN-1:0] instrIn,
  input  logic [XLEN-1:0] pcIn,
  output logic            valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pcPlus4
);

  always_ff @(posedge clk) begin
    if (reset) begin
      valid   <= 1'b0;
      instr   <= NOP_INSTR;
      pc      <= '0;
      pcPlus4 <= '0;
    end else if (flush) begin
      valid <= 1'b0;
      instr <= NOP_INSTR;
    end else if (stall) begin
      // hold everything
    end else if (load) begin
      valid   <= 1'b1;
      instr   <= instrIn;
      pc      <= pcIn;
      pcPlus4 <= pcIn + 32'd4;
    end else begin
      // bubble: PC fields keep their last value, only validity and opcode change
      valid <= 1'b0;
      instr <= NOP_INSTR;
    end
  end

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage with single outstanding request
// Purpose: drives instruction-memory requests, tracks the fetch PC and
//          feeds the IF/ID register, honouring stall and branch flush.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   stall, flush, branch_target     hazard hold / taken-branch redirect
//   imem_req_valid/ready, imem_addr request channel
//   imem_rsp_valid, imem_rdata      response channel
//   if_id_valid/instr/pc/pc_plus4   IF/ID register outputs
module if_stage
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            flush,
  input  logic [XLEN-1:0] branch_target,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            if_id_valid,
  output logic [XLEN-1:0] if_id_instr,
  output logic [XLEN-1:0] if_id_pc,
  output logic [XLEN-1:0] if_id_pc_plus4
);

  fetchStateT      state, nextState;
  logic [XLEN-1:0] pc, nextPc;
  logic [XLEN-1:0] fetchPc, nextFetchPc;
  logic [XLEN-1:0] bufInstr;
  logic            bufLoad;
  logic            ifIdLoad;
  logic [XLEN-1:0] ifIdInstrIn;
  logic [XLEN-1:0] alignedTarget;

  assign alignedTarget = branch_target & ~32'h0000_0003;

  // State register plus the PC / fetch PC / response buffer it owns.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_REQ;
      pc       <= RESET_PC;
      fetchPc  <= RESET_PC;
      bufInstr <= NOP_INSTR;
    end else begin
      state   <= nextState;
      pc      <= nextPc;
      fetchPc <= nextFetchPc;
      if (bufLoad) bufInstr <= imem_rdata;
    end
  end

  // Next-state and datapath control. Flush overrides stall in every state.
  always_comb begin
    nextState   = state;
    nextPc      = pc;
    nextFetchPc = fetchPc;
    bufLoad     = 1'b0;
    ifIdLoad    = 1'b0;
    ifIdInstrIn = imem_rdata;
    if (flush) begin
      nextPc = alignedTarget;
      case (state)
        // a request is still in flight unless its response is here now
        S_WAIT, S_DROP: nextState = imem_rsp_valid ? S_REQ : S_DROP;
        default:        nextState = S_REQ;
      endcase
    end else begin
      case (state)
        S_REQ: begin
          if (imem_req_ready) begin
            nextFetchPc = pc;
            nextState   = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            if (stall) begin
              bufLoad   = 1'b1;
              nextState = S_HOLD;
            end else begin
              ifIdLoad  = 1'b1;
              nextPc    = fetchPc + 32'd4;
              nextState = S_REQ;
            end
          end
        end
        S_HOLD: begin
          if (!stall) begin
            ifIdLoad    = 1'b1;
            ifIdInstrIn = bufInstr;
            nextPc      = fetchPc + 32'd4;
            nextState   = S_REQ;
          end
        end
        S_DROP: begin
          if (imem_rsp_valid) nextState = S_REQ;
        end
        default: nextState = S_REQ;
      endcase
    end
  end

  // Outputs: the address stays on pc, which only moves on delivery or flush.
  always_comb begin
    imem_req_valid = (state == S_REQ) && !flush;
    imem_addr      = pc;
  end

  if_id_reg u_if_id_reg (
    .clk     (clk),
    .reset   (reset),
    .flush   (flush),
    .stall   (stall),
    .load    (ifIdLoad),
    .instrIn (ifIdInstrIn),
    .pcIn    (fetchPc),
    .valid   (if_id_valid),
    .instr   (if_id_instr),
    .pc      (if_id_pc),
    .pcPlus4 (if_id_pc_plus4)
  );

endmodule
